// File: rtl/img_stream_loader.sv
// img_stream_loader
// Moves a fixed-size block of pixel bytes between a byte stream and a
// byte-wide data memory that has a registered read port.
//   load : stream (s_data/s_valid/s_ready) -> memory writes (dAddr/d_in/MEM_WRITE)
//   dump : memory reads (dAddr/mem_rdata) -> stream (m_data/m_valid/m_ready)
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   start_load, start_dump    transfer requests, sampled only while idle
//   s_data, s_valid, s_ready  inbound byte stream
//   m_data, m_valid, m_ready  outbound byte stream
//   dAddr, d_in, MEM_WRITE    data-memory address, write byte, write strobe
//   mem_rdata                 data-memory read byte, one cycle after address
//   busy, done                transfer in progress, one-cycle completion pulse
// Handshake: a byte moves on a cycle where valid and ready are both high at
// the rising edge; a source holds valid and data stable until that happens.
module img_stream_loader #(
    parameter int BASE_ADDR = 0,
    parameter int NUM_BYTES = 65536
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_load,
    input  logic        start_dump,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [7:0]  m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [18:0] dAddr,
    output logic [7:0]  d_in,
    output logic        MEM_WRITE,
    input  logic [7:0]  mem_rdata,
    output logic        busy,
    output logic        done
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] LOAD    = 3'd1;
    localparam logic [2:0] RD_ADDR = 3'd2;
    localparam logic [2:0] RD_CAP  = 3'd3;
    localparam logic [2:0] RD_OUT  = 3'd4;

    localparam logic [18:0] LAST_CNT = 19'(NUM_BYTES - 1);
    localparam logic [18:0] BASE     = 19'(BASE_ADDR);

    logic [2:0]  state_q, state_d;
    logic [18:0] cnt_q, cnt_d;
    logic [7:0]  m_data_q, m_data_d;
    logic        done_q, done_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        m_data_d = m_data_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                // Load has priority when both requests arrive together.
                if (start_load) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end else if (start_dump) begin
                    state_d = RD_ADDR;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                if (s_valid) begin
                    if (cnt_q == LAST_CNT) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 19'd1;
                    end
                end
            end
            // Address is presented here; the memory registers it at the edge.
            RD_ADDR: state_d = RD_CAP;
            // mem_rdata now holds the byte for cnt; capture it for output.
            RD_CAP: begin
                m_data_d = mem_rdata;
                state_d  = RD_OUT;
            end
            RD_OUT: begin
                if (m_ready) begin
                    if (cnt_q == LAST_CNT) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d   = cnt_q + 19'd1;
                        state_d = RD_ADDR;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            m_data_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            m_data_q <= m_data_d;
            done_q   <= done_d;
        end
    end

    // Stream-side outputs decode straight from the registered state so that
    // reset forces them low without waiting for a clock edge.
    assign s_ready   = (state_q == LOAD);
    assign MEM_WRITE = s_ready & s_valid;
    assign d_in      = s_ready ? s_data : 8'd0;
    assign m_valid   = (state_q == RD_OUT);
    assign m_data    = m_data_q;
    assign busy      = (state_q != IDLE);
    // done is registered and fires in the first IDLE cycle, so it never
    // overlaps busy.
    assign done      = done_q;
    assign dAddr     = BASE + cnt_q;

endmodule

// File: tb/tb_img_stream_loader.sv
// Bench for img_stream_loader with NUM_BYTES=4, BASE_ADDR=16.
// The bench keeps its own picture of the four-byte image (what it loaded),
// expects every memory write as {address, byte} and every outbound byte in
// order, and checks them on each falling edge.
module tb_img_stream_loader;

    localparam int BASE = 16;
    localparam int NB   = 4;

    logic        clk;
    logic        rst;
    logic        start_load, start_dump;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready;
    logic [18:0] dAddr;
    logic [7:0]  d_in;
    logic        MEM_WRITE;
    logic [7:0]  mem_rdata;
    logic        busy, done;

    img_stream_loader #(.BASE_ADDR(BASE), .NUM_BYTES(NB)) dut (
        .clk(clk), .rst(rst),
        .start_load(start_load), .start_dump(start_dump),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .dAddr(dAddr), .d_in(d_in), .MEM_WRITE(MEM_WRITE),
        .mem_rdata(mem_rdata), .busy(busy), .done(done)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // data memory with registered read
    logic [7:0] ram [0:63];
    always @(posedge clk) begin
        if (MEM_WRITE) ram[dAddr[5:0]] <= d_in;
        mem_rdata <= ram[dAddr[5:0]];
    end

    // counts
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // model of the image and scoreboard queues
    logic [7:0]  img [0:NB-1];
    logic [26:0] exp_wr_q [$];
    logic [7:0]  exp_q [$];
    int          hs_cyc_q [$];

    int         cyc = 0;
    int         done_n = 0;
    int         wr_n = 0;
    int         hs_n = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'd0;

    always @(posedge clk) cyc <= cyc + 1;

    // compare process
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            check("done_busy_excl", {31'd0, done && busy}, 32'd0);
            if (MEM_WRITE) begin
                wr_n++;
                if (exp_wr_q.size() == 0) check("unexpected_write", {13'd0, dAddr}, 32'hFFFF_FFFF);
                else check("write_addr_data", {5'd0, dAddr, d_in}, {5'd0, exp_wr_q.pop_front()});
            end
            if (m_valid && prev_stall) check("m_data_hold", {24'd0, m_data}, {24'd0, prev_data});
            if (m_valid && m_ready) begin
                hs_n++;
                hs_cyc_q.push_back(cyc);
                if (exp_q.size() == 0) check("unexpected_out", {24'd0, m_data}, 32'hFFFF_FFFF);
                else check("m_data", {24'd0, m_data}, {24'd0, exp_q.pop_front()});
            end
            if (done) done_n++;
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_write(input int idx, input logic [7:0] b);
        logic [18:0] a;
        a = 19'(BASE + idx);
        exp_wr_q.push_back({a, b});
        img[idx] = b;
    endtask

    // Load NB bytes. toggle inserts an idle s_valid cycle between bytes,
    // both raises start_dump with start_load and again mid-load,
    // rel releases reset in the same cycle as the start request.
    task automatic do_load(input logic [7:0] b [NB], input bit toggle, input bit both, input bit rel);
        int d0, w0;
        d0 = done_n;
        w0 = wr_n;
        start_load = 1'b1;
        start_dump = both;
        if (rel) rst = 1'b0;
        tick();
        start_load = 1'b0;
        start_dump = 1'b0;
        check("s_ready_after_start", {31'd0, s_ready}, 32'd1);
        check("busy_after_start", {31'd0, busy}, 32'd1);
        for (int i = 0; i < NB; i++) begin
            s_valid = 1'b1;
            s_data  = b[i];
            if (both && i == 1) start_dump = 1'b1;
            expect_write(i, b[i]);
            tick();
            start_dump = 1'b0;
            if (i < NB - 1) check("s_ready_mid_load", {31'd0, s_ready}, 32'd1);
            if (toggle && i < NB - 1) begin
                s_valid = 1'b0;
                s_data  = 8'hEE;
                tick();
            end
        end
        s_valid = 1'b0;
        check("done_after_load", {31'd0, done}, 32'd1);
        check("busy_after_load", {31'd0, busy}, 32'd0);
        tick();
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("load_done_count", done_n - d0, 32'd1);
        check("load_write_count", wr_n - w0, NB);
        check("load_queue_drained", exp_wr_q.size(), 32'd0);
    endtask

    // Dump all bytes; stall m_ready for stall_len cycles on byte stall_idx.
    task automatic do_dump(input int stall_idx, input int stall_len);
        int base, d0, s, guard, stall_left;
        base = hs_n;
        d0   = done_n;
        hs_cyc_q.delete();
        for (int i = 0; i < NB; i++) exp_q.push_back(img[i]);
        m_ready    = 1'b1;
        start_dump = 1'b1;
        tick();
        start_dump = 1'b0;
        s = cyc;
        stall_left = stall_len;
        guard = 0;
        while (!done && guard < 100) begin
            if (m_valid && (hs_n - base) == stall_idx && stall_left > 0) begin
                m_ready = 1'b0;
                stall_left--;
                check("stall_addr", {13'd0, dAddr}, BASE + stall_idx);
                check("stall_data", {24'd0, m_data}, {24'd0, img[stall_idx]});
            end else begin
                m_ready = 1'b1;
            end
            tick();
            guard++;
        end
        m_ready = 1'b1;
        check("dump_timeout", {31'd0, guard < 100}, 32'd1);
        check("dump_busy_end", {31'd0, busy}, 32'd0);
        check("dump_mvalid_end", {31'd0, m_valid}, 32'd0);
        check("dump_bytes", hs_n - base, NB);
        check("dump_queue_drained", exp_q.size(), 32'd0);
        if (stall_len == 0 && hs_cyc_q.size() == NB) begin
            check("read_latency", hs_cyc_q[0] - s, 32'd2);
            for (int k = 1; k < NB; k++) check("dump_spacing", hs_cyc_q[k] - hs_cyc_q[k-1], 32'd3);
        end
        tick();
        check("dump_done_count", done_n - d0, 32'd1);
    endtask

    logic [7:0] pat_a [NB];
    logic [7:0] pat_b [NB];
    logic [7:0] pat_c [NB];
    logic [7:0] pat_d [NB];

    initial begin
        pat_a = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        pat_b = '{8'h50, 8'h51, 8'h52, 8'h53};
        pat_c = '{8'h60, 8'h61, 8'h62, 8'h63};
        pat_d = '{8'h80, 8'h81, 8'h82, 8'h83};
        rst = 1'b1;
        start_load = 1'b0;
        start_dump = 1'b0;
        s_data = 8'd0;
        s_valid = 1'b0;
        m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_s_ready", {31'd0, s_ready}, 32'd0);
        check("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("rst_mem_write", {31'd0, MEM_WRITE}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_m_data", {24'd0, m_data}, 32'd0);
        check("rst_daddr", {13'd0, dAddr}, 32'd16);
        rst = 1'b0;
        tick();

        // s_valid toggling, then continuous load, then dumps
        do_load(pat_b, 1'b1, 1'b0, 1'b0);
        do_load(pat_a, 1'b0, 1'b0, 1'b0);
        do_dump(-1, 0);
        do_dump(2, 5);

        // simultaneous starts: load wins, mid-load start_dump ignored
        do_load(pat_c, 1'b0, 1'b1, 1'b0);

        // reset after the second load byte
        start_load = 1'b1;
        tick();
        start_load = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_valid = 1'b1;
            s_data  = 8'h70 + 8'(i);
            expect_write(i, 8'h70 + 8'(i));
            tick();
        end
        s_data = 8'h72;
        rst = 1'b1;
        #1;
        check("rst_mid_mem_write", {31'd0, MEM_WRITE}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_s_ready", {31'd0, s_ready}, 32'd0);
        s_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        check("rst_mid_no_done", {31'd0, done}, 32'd0);
        check("rst_mid_queue", exp_wr_q.size(), 32'd0);
        // earlier bytes must be retained: image is 70,71,62,63
        do_dump(-1, 0);

        // start accepted on the first edge after reset release
        rst = 1'b1;
        tick();
        do_load(pat_d, 1'b0, 1'b0, 1'b1);
        do_dump(-1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // overall time limit
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/img_stream_loader.md
IMG_STREAM_LOADER -- requirements
Module: img_stream_loader

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 0, first data-memory byte address used.
REQ-002 The block SHALL have parameter NUM_BYTES, default 65536, bytes per load or dump; legal range 1..262145 with BASE_ADDR+NUM_BYTES-1 <= 262144.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port start_load  input  1  request stream-to-memory transfer.
REQ-006 The block SHALL have port start_dump  input  1  request memory-to-stream transfer.
REQ-007 The block SHALL have port s_data  input  8  inbound pixel byte.
REQ-008 The block SHALL have port s_valid  input  1  s_data valid.
REQ-009 The block SHALL have port s_ready  output  1  block accepts s_data.
REQ-010 The block SHALL have port m_data  output  8  outbound pixel byte.
REQ-011 The block SHALL have port m_valid  output  1  m_data valid.
REQ-012 The block SHALL have port m_ready  input  1  sink accepts m_data.
REQ-013 The block SHALL have port dAddr  output  19  data-memory byte address.
REQ-014 The block SHALL have port d_in  output  8  data-memory write byte.
REQ-015 The block SHALL have port MEM_WRITE  output  1  data-memory write strobe.
REQ-016 The block SHALL have port mem_rdata  input  8  data-memory registered read output (valid one cycle after address presented with MEM_WRITE low).
REQ-017 The block SHALL have ports busy  output  1  transfer in progress; done  output  1  one-cycle completion pulse.

Function
REQ-018 The FSM SHALL have states IDLE, LOAD, RD_ADDR, RD_CAP, RD_OUT; 19-bit counter cnt.
REQ-019 dAddr SHALL equal BASE_ADDR+cnt in every state (combinational).
REQ-020 IDLE: start_load -> LOAD, cnt=0; else start_dump -> RD_ADDR, cnt=0; both high same cycle -> LOAD wins; starts outside IDLE SHALL be ignored.
REQ-021 LOAD: s_ready=1; d_in=s_data; MEM_WRITE=s_valid (combinational); on s_valid, cnt increments.
REQ-022 LOAD: handshake with cnt==NUM_BYTES-1 SHALL write that byte, go IDLE, pulse done next cycle-edge output for exactly one cycle.
REQ-023 LOAD with s_valid low SHALL hold cnt, MEM_WRITE=0, no write.
REQ-024 RD_ADDR: MEM_WRITE=0, unconditional -> RD_CAP.
REQ-025 RD_CAP: m_data <= mem_rdata, -> RD_OUT; read latency address-to-m_valid = 2 cycles.
REQ-026 RD_OUT: m_valid=1, m_data stable until m_ready; on m_ready: cnt==NUM_BYTES-1 -> IDLE with done pulse, else cnt+1, -> RD_ADDR.
REQ-027 MEM_WRITE SHALL be 0 in every state except LOAD; s_ready 0 outside LOAD; m_valid 0 outside RD_OUT.
REQ-028 busy SHALL be 1 in every state except IDLE; done and busy never both 1.
REQ-029 cnt SHALL never exceed NUM_BYTES-1; NUM_BYTES=1 completes after one handshake.
REQ-030 Dump throughput SHALL be one byte per 3 cycles with m_ready held high.

Reset
REQ-031 rst high SHALL immediately force IDLE, cnt=0, m_data=0, and outputs s_ready, m_valid, MEM_WRITE, busy, done = 0; d_in=0 not required (don't-care when MEM_WRITE=0).
REQ-032 Reset mid-transfer SHALL abort without further writes; memory contents already written are retained, not cleared.
REQ-033 After rst deasserts, the block SHALL accept a new start on the first clock edge.

Verification
REQ-034 NUM_BYTES=4, BASE_ADDR=16: load 0xA0,0xA1,0xA2,0xA3 with s_valid always high -> MEM_WRITE high 4 cycles, addresses 16..19, done pulse once, busy 0 after.
REQ-035 Same load with s_valid toggled 1,0,1,0... -> 4 writes only on s_valid cycles, addresses contiguous, no duplicate write.
REQ-036 Dump after REQ-034 with m_ready high -> m_data 0xA0..0xA3 in order, m_valid spacing 3 cycles, done pulse after 4th.
REQ-037 Dump with m_ready low 5 cycles on byte 2 -> m_data=0xA2 held stable, m_valid held, no address advance.
REQ-038 start_load and start_dump high together in IDLE -> LOAD entered, s_ready=1; start_dump during LOAD ignored.
REQ-039 rst asserted after 2nd load byte -> MEM_WRITE=0 at once, busy=0, no done; reload then writes from BASE_ADDR.
